recv_splitter: RTL and testbench

- Receive-side counterpart of the send merger: takes the single inbound stream of parsed TCP packets from the network receive path and splits it into two streams.
- Data-bearing packets go to the rx pipe. Zero-payload control/ACK packets go to the control pipe.
- Each destination is decoupled by its own 2-entry registered FIFO, so one stalled consumer does not stall the other until its FIFO fills.

---
 rtl/recv_splitter.sv | 235 +++++++++++++++++++++++
 tb/tb_recv_splitter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/recv_splitter.sv
// Splits parsed RX packets: payload-bearing -> data pipe, zero-payload -> ctrl pipe, each via its own registered FIFO.
// Latency 1 cycle min; inbound rdy = ~full of the selected FIFO only (head-of-line holds). Optional stats: RECV_SPLITTER_STATS_EN.

package recv_splitter_pkg;
    localparam int FLOWID_W  = 16;
    localparam int IP_ADDR_W = 32;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [3:0]  data_offset;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_pkt_hdr;

    typedef struct packed {
        logic [31:0] buf_addr;
        logic [15:0] payload_len;
    } payload_buf_struct;

    typedef struct packed {
        logic [FLOWID_W-1:0]  flowid;
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
        tcp_pkt_hdr           tcp_hdr;
        payload_buf_struct    payload;
    } data_ent_t;

    typedef struct packed {
        logic [FLOWID_W-1:0]  flowid;
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
        tcp_pkt_hdr           tcp_hdr;
    } ctrl_ent_t;
endpackage

module recv_splitter_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    output logic         o_full,
    output logic         o_rd_vld,
    output logic [W-1:0] o_rd_dat,
    input  logic         i_rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_wr;
    logic          w_rd;

    // Full is taken from the pre-dequeue count, so a full FIFO never accepts even while draining.
    assign o_full   = (r_cnt == CW'(DEPTH));
    assign o_rd_vld = (r_cnt != '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_wr     = i_wr_vld & ~o_full;
    assign w_rd     = o_rd_vld & i_rd_rdy;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module recv_splitter
    import recv_splitter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_splitter_rx_val,
    input  logic [FLOWID_W-1:0]  src_splitter_rx_flowid,
    input  logic [IP_ADDR_W-1:0] src_splitter_rx_src_ip,
    input  logic [IP_ADDR_W-1:0] src_splitter_rx_dst_ip,
    input  tcp_pkt_hdr           src_splitter_rx_tcp_hdr,
    input  payload_buf_struct    src_splitter_rx_payload,
    output logic                 splitter_src_rx_rdy,
    output logic                 splitter_data_rx_val,
    output logic [FLOWID_W-1:0]  splitter_data_rx_flowid,
    output logic [IP_ADDR_W-1:0] splitter_data_rx_src_ip,
    output logic [IP_ADDR_W-1:0] splitter_data_rx_dst_ip,
    output tcp_pkt_hdr           splitter_data_rx_tcp_hdr,
    output payload_buf_struct    splitter_data_rx_payload,
    input  logic                 data_splitter_rx_rdy,
    output logic                 splitter_ctrl_rx_val,
    output logic [FLOWID_W-1:0]  splitter_ctrl_rx_flowid,
    output logic [IP_ADDR_W-1:0] splitter_ctrl_rx_src_ip,
    output logic [IP_ADDR_W-1:0] splitter_ctrl_rx_dst_ip,
    output tcp_pkt_hdr           splitter_ctrl_rx_tcp_hdr,
    input  logic                 ctrl_splitter_rx_rdy
`ifdef RECV_SPLITTER_STATS_EN
    ,
    output logic [CNT_W-1:0]     splitter_stat_data_cnt,
    output logic [CNT_W-1:0]     splitter_stat_ctrl_cnt,
    output logic [CNT_W-1:0]     splitter_stat_stall_cnt
`endif
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("recv_splitter: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("recv_splitter: CNT_W must be at least 1");
    end

    logic      w_is_data;
    logic      w_data_full;
    logic      w_ctrl_full;
    logic      w_accept;
    logic      w_data_enq;
    logic      w_ctrl_enq;
    data_ent_t w_data_in;
    data_ent_t w_data_out;
    ctrl_ent_t w_ctrl_in;
    ctrl_ent_t w_ctrl_out;

    // Routing is by payload length alone; SYN/FIN/RST carrying data stay on the data path.
    assign w_is_data           = (src_splitter_rx_payload.payload_len != '0);
    assign splitter_src_rx_rdy = w_is_data ? ~w_data_full : ~w_ctrl_full;
    assign w_accept            = src_splitter_rx_val & splitter_src_rx_rdy;
    assign w_data_enq          = w_accept & w_is_data;
    assign w_ctrl_enq          = w_accept & ~w_is_data;

    assign w_data_in = '{flowid:  src_splitter_rx_flowid,
                         src_ip:  src_splitter_rx_src_ip,
                         dst_ip:  src_splitter_rx_dst_ip,
                         tcp_hdr: src_splitter_rx_tcp_hdr,
                         payload: src_splitter_rx_payload};
    assign w_ctrl_in = '{flowid:  src_splitter_rx_flowid,
                         src_ip:  src_splitter_rx_src_ip,
                         dst_ip:  src_splitter_rx_dst_ip,
                         tcp_hdr: src_splitter_rx_tcp_hdr};

    recv_splitter_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(data_ent_t))) u_data_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_data_enq),
        .i_wr_dat (w_data_in),
        .o_full   (w_data_full),
        .o_rd_vld (splitter_data_rx_val),
        .o_rd_dat (w_data_out),
        .i_rd_rdy (data_splitter_rx_rdy)
    );

    recv_splitter_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ctrl_ent_t))) u_ctrl_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_ctrl_enq),
        .i_wr_dat (w_ctrl_in),
        .o_full   (w_ctrl_full),
        .o_rd_vld (splitter_ctrl_rx_val),
        .o_rd_dat (w_ctrl_out),
        .i_rd_rdy (ctrl_splitter_rx_rdy)
    );

    assign splitter_data_rx_flowid  = w_data_out.flowid;
    assign splitter_data_rx_src_ip  = w_data_out.src_ip;
    assign splitter_data_rx_dst_ip  = w_data_out.dst_ip;
    assign splitter_data_rx_tcp_hdr = w_data_out.tcp_hdr;
    assign splitter_data_rx_payload = w_data_out.payload;
    assign splitter_ctrl_rx_flowid  = w_ctrl_out.flowid;
    assign splitter_ctrl_rx_src_ip  = w_ctrl_out.src_ip;
    assign splitter_ctrl_rx_dst_ip  = w_ctrl_out.dst_ip;
    assign splitter_ctrl_rx_tcp_hdr = w_ctrl_out.tcp_hdr;

`ifdef RECV_SPLITTER_STATS_EN
    logic [CNT_W-1:0] r_stat_data;
    logic [CNT_W-1:0] r_stat_ctrl;
    logic [CNT_W-1:0] r_stat_stall;
    logic             w_stall;

    assign w_stall = src_splitter_rx_val & ~splitter_src_rx_rdy;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_data  <= '0;
            r_stat_ctrl  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_data_enq && r_stat_data != '1) begin
                r_stat_data <= r_stat_data + CNT_W'(1);
            end
            if (w_ctrl_enq && r_stat_ctrl != '1) begin
                r_stat_ctrl <= r_stat_ctrl + CNT_W'(1);
            end
            if (w_stall && r_stat_stall != '1) begin
                r_stat_stall <= r_stat_stall + CNT_W'(1);
            end
        end
    end

    assign splitter_stat_data_cnt  = r_stat_data;
    assign splitter_stat_ctrl_cnt  = r_stat_ctrl;
    assign splitter_stat_stall_cnt = r_stat_stall;
`endif
endmodule

// File: tb/tb_recv_splitter.sv
// Bench for recv_splitter: directed scenarios then random traffic against a queue-based reference model.
module tb_recv_splitter;
    import recv_splitter_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_val = 1'b0;
    data_ent_t            in_pkt = '0;
    logic                 d_rdy = 1'b0;
    logic                 c_rdy = 1'b0;

    logic                 splitter_src_rx_rdy;
    logic                 splitter_data_rx_val;
    logic [FLOWID_W-1:0]  splitter_data_rx_flowid;
    logic [IP_ADDR_W-1:0] splitter_data_rx_src_ip;
    logic [IP_ADDR_W-1:0] splitter_data_rx_dst_ip;
    tcp_pkt_hdr           splitter_data_rx_tcp_hdr;
    payload_buf_struct    splitter_data_rx_payload;
    logic                 splitter_ctrl_rx_val;
    logic [FLOWID_W-1:0]  splitter_ctrl_rx_flowid;
    logic [IP_ADDR_W-1:0] splitter_ctrl_rx_src_ip;
    logic [IP_ADDR_W-1:0] splitter_ctrl_rx_dst_ip;
    tcp_pkt_hdr           splitter_ctrl_rx_tcp_hdr;
`ifdef RECV_SPLITTER_STATS_EN
    logic [CW-1:0]        stat_data;
    logic [CW-1:0]        stat_ctrl;
    logic [CW-1:0]        stat_stall;
    int                   m_dcnt = 0;
    int                   m_ccnt = 0;
    int                   m_scnt = 0;
`endif

    data_ent_t dq[$];
    ctrl_ent_t cq[$];
    int        errors = 0;
    int        checks = 0;

    always #5 clk = ~clk;

    recv_splitter #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .src_splitter_rx_val      (in_val),
        .src_splitter_rx_flowid   (in_pkt.flowid),
        .src_splitter_rx_src_ip   (in_pkt.src_ip),
        .src_splitter_rx_dst_ip   (in_pkt.dst_ip),
        .src_splitter_rx_tcp_hdr  (in_pkt.tcp_hdr),
        .src_splitter_rx_payload  (in_pkt.payload),
        .splitter_src_rx_rdy      (splitter_src_rx_rdy),
        .splitter_data_rx_val     (splitter_data_rx_val),
        .splitter_data_rx_flowid  (splitter_data_rx_flowid),
        .splitter_data_rx_src_ip  (splitter_data_rx_src_ip),
        .splitter_data_rx_dst_ip  (splitter_data_rx_dst_ip),
        .splitter_data_rx_tcp_hdr (splitter_data_rx_tcp_hdr),
        .splitter_data_rx_payload (splitter_data_rx_payload),
        .data_splitter_rx_rdy     (d_rdy),
        .splitter_ctrl_rx_val     (splitter_ctrl_rx_val),
        .splitter_ctrl_rx_flowid  (splitter_ctrl_rx_flowid),
        .splitter_ctrl_rx_src_ip  (splitter_ctrl_rx_src_ip),
        .splitter_ctrl_rx_dst_ip  (splitter_ctrl_rx_dst_ip),
        .splitter_ctrl_rx_tcp_hdr (splitter_ctrl_rx_tcp_hdr),
        .ctrl_splitter_rx_rdy     (c_rdy)
`ifdef RECV_SPLITTER_STATS_EN
        ,
        .splitter_stat_data_cnt   (stat_data),
        .splitter_stat_ctrl_cnt   (stat_ctrl),
        .splitter_stat_stall_cnt  (stat_stall)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic data_ent_t mk(input int fid, input int len, input logic [7:0] flags);
        data_ent_t p;
        p.flowid               = FLOWID_W'(fid);
        p.src_ip               = $urandom;
        p.dst_ip               = $urandom;
        p.tcp_hdr.src_port     = 16'($urandom);
        p.tcp_hdr.dst_port     = 16'($urandom);
        p.tcp_hdr.seq_num      = $urandom;
        p.tcp_hdr.ack_num      = $urandom;
        p.tcp_hdr.data_offset  = 4'd5;
        p.tcp_hdr.flags        = flags;
        p.tcp_hdr.window       = 16'($urandom);
        p.payload.buf_addr     = $urandom;
        p.payload.payload_len  = 16'(len);
        return p;
    endfunction

    function automatic ctrl_ent_t to_ctrl(input data_ent_t p);
        return '{flowid: p.flowid, src_ip: p.src_ip, dst_ip: p.dst_ip, tcp_hdr: p.tcp_hdr};
    endfunction

    function automatic int sat(input int c);
        return (c >= (1 << CW) - 1) ? c : c + 1;
    endfunction

    // One clock cycle: drive, check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step(input logic v, input data_ent_t p, input logic drdy, input logic crdy,
                        output logic acc, output logic obs_rdy);
        bit        isd;
        bit        erdy;
        data_ent_t dobs;
        ctrl_ent_t cobs;
        in_val = v;
        in_pkt = p;
        d_rdy  = drdy;
        c_rdy  = crdy;
        @(negedge clk);
        isd  = (p.payload.payload_len != 0);
        erdy = isd ? (dq.size() < DEPTH) : (cq.size() < DEPTH);
        obs_rdy = splitter_src_rx_rdy;
        chk("src_rdy", 256'(splitter_src_rx_rdy), 256'(erdy));
        chk("data_val", 256'(splitter_data_rx_val), 256'(dq.size() != 0));
        chk("ctrl_val", 256'(splitter_ctrl_rx_val), 256'(cq.size() != 0));
        if (dq.size() != 0) begin
            dobs = '{flowid: splitter_data_rx_flowid, src_ip: splitter_data_rx_src_ip,
                     dst_ip: splitter_data_rx_dst_ip, tcp_hdr: splitter_data_rx_tcp_hdr,
                     payload: splitter_data_rx_payload};
            chk("data_pkt", 256'(dobs), 256'(dq[0]));
        end
        if (cq.size() != 0) begin
            cobs = '{flowid: splitter_ctrl_rx_flowid, src_ip: splitter_ctrl_rx_src_ip,
                     dst_ip: splitter_ctrl_rx_dst_ip, tcp_hdr: splitter_ctrl_rx_tcp_hdr};
            chk("ctrl_pkt", 256'(cobs), 256'(cq[0]));
        end
`ifdef RECV_SPLITTER_STATS_EN
        chk("stat_data", 256'(stat_data), 256'(m_dcnt));
        chk("stat_ctrl", 256'(stat_ctrl), 256'(m_ccnt));
        chk("stat_stall", 256'(stat_stall), 256'(m_scnt));
`endif
        acc = v & erdy;
        @(posedge clk);
        if (drdy && dq.size() != 0) void'(dq.pop_front());
        if (crdy && cq.size() != 0) void'(cq.pop_front());
        if (acc && isd) dq.push_back(p);
        if (acc && !isd) cq.push_back(to_ctrl(p));
`ifdef RECV_SPLITTER_STATS_EN
        if (acc && isd) m_dcnt = sat(m_dcnt);
        if (acc && !isd) m_ccnt = sat(m_ccnt);
        if (v && !erdy) m_scnt = sat(m_scnt);
`endif
        #1;
    endtask

    initial begin
        logic      acc;
        logic      r;
        data_ent_t p;
        data_ent_t pc;
        bit        have_p;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_data_val", 256'(splitter_data_rx_val), 256'(0));
        chk("reset_ctrl_val", 256'(splitter_ctrl_rx_val), 256'(0));
        chk("reset_src_rdy", 256'(splitter_src_rx_rdy), 256'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single data packet, then a pure ACK.
        p = mk(3, 64, 8'h10);
        step(1'b1, p, 1'b1, 1'b1, acc, r);
        chk("t1_accepted", 256'(r), 256'(1));
        repeat (2) step(1'b0, p, 1'b1, 1'b1, acc, r);
        p = mk(9, 0, 8'h1 << FLAG_ACK);
        step(1'b1, p, 1'b1, 1'b1, acc, r);
        repeat (2) step(1'b0, p, 1'b1, 1'b1, acc, r);

        // Data consumer stalled: third data packet and the ctrl packet behind it are held.
        step(1'b1, mk(0, 100, 8'h0), 1'b0, 1'b1, acc, r);
        step(1'b1, mk(1, 200, 8'h1 << FLAG_SYN), 1'b0, 1'b1, acc, r);
        p  = mk(2, 1, 8'h1 << FLAG_FIN);
        pc = mk(7, 0, 8'h1 << FLAG_ACK);
        step(1'b1, p, 1'b0, 1'b1, acc, r);
        chk("third_blocked", 256'(r), 256'(0));
        step(1'b1, p, 1'b0, 1'b1, acc, r);
        chk("third_still_blocked", 256'(r), 256'(0));
        step(1'b1, p, 1'b1, 1'b1, acc, r);
        chk("full_with_dequeue", 256'(r), 256'(0));
        step(1'b1, p, 1'b1, 1'b1, acc, r);
        chk("accepted_after_drain", 256'(r), 256'(1));
        step(1'b1, pc, 1'b1, 1'b1, acc, r);
        repeat (4) step(1'b0, pc, 1'b1, 1'b1, acc, r);

        // Asynchronous reset with one packet in each FIFO.
        step(1'b1, mk(4, 33, 8'h0), 1'b0, 1'b0, acc, r);
        step(1'b1, mk(5, 0, 8'h1 << FLAG_RST), 1'b0, 1'b0, acc, r);
        in_val = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data_val", 256'(splitter_data_rx_val), 256'(0));
        chk("async_rst_ctrl_val", 256'(splitter_ctrl_rx_val), 256'(0));
        dq.delete();
        cq.delete();
`ifdef RECV_SPLITTER_STATS_EN
        m_dcnt = 0;
        m_ccnt = 0;
        m_scnt = 0;
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 256'(splitter_src_rx_rdy), 256'(1));
        @(posedge clk);
        #1;

        // Random traffic; a presented packet is held until accepted.
        have_p = 1'b0;
        p = mk(0, 0, 8'h0);
        for (int i = 0; i < 400; i++) begin
            if (!have_p && $urandom_range(0, 3) != 0) begin
                p = mk(i, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 1500) : 0, 8'($urandom));
                have_p = 1'b1;
            end
            step(have_p, p, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, acc, r);
            if (acc) have_p = 1'b0;
        end
        repeat (6) step(1'b0, p, 1'b1, 1'b1, acc, r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
